playbus_controller: RTL
=======================

// Module: playbus_controller
// PURPOSE
//  Bus sequencer/arbiter for the PlayBus emulator: shares the 4-bit data bus between two requesters.
//  Generates CS/OE/WE for eprom, ram and the switch buffer, plus the register load strobe.
//  Guarantees exactly one bus driver per transaction, so contention.contend never asserts.
//  Sits between the requesters (switches/test sequencer) and the bus components.
// PARAMETERS
//  AW  3  address width; matches 8-word ROM/RAM
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  n_reset   in   1   asynchronous, active-low reset
//  req       in   2   request, bit i = requester i; held until done seen
//  op0       in   2   requester 0 op: 00 ROM_RD, 01 RAM_RD, 10 SW_WR, 11 COPY
//  op1       in   2   requester 1 op, same encoding
//  addr0     in   AW  requester 0 address
//  addr1     in   AW  requester 1 address
//  grant     out  2   one-hot owner of the current transaction
//  done      out  1   single-cycle completion pulse
//  busy      out  1   state != IDLE
//  address   out  AW  bus address to ROM/RAM
//  rom_cs, rom_oe    out 1  eprom enables
//  ram_cs, ram_oe    out 1  ram select/output enable
//  ram_we            out 1  ram write strobe
//  buf_cs, buf_oe    out 1  switch buffer enables
//  reg_oe            out 1  register load enable
// BEHAVIOUR
//  Reset (async, n_reset=0): state=IDLE; every output 0; last_winner=1 (requester 0 wins first).
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> [TURN] -> IDLE.
//  - IDLE: if req!=0, pick winner and latch its op/addr; next state SETUP. Otherwise stay.
//  - SETUP: grant=winner, address=latched addr; driver CS/OE=1; strobe=0.
//  - STROBE: as SETUP, plus strobe=1. Data is captured on the edge that ends STROBE.
//  - HOLD: driver still on; strobe=0; done=1; grant still asserted.
//  - Exit: HOLD goes to TURN, or to IDLE when the macro is absent. TURN: all enables 0, grant=0.
//  Driver/strobe by op:
//  - ROM_RD: driver rom, strobe reg_oe
//  - RAM_RD: driver ram_oe, strobe reg_oe
//  - SW_WR: driver buf, strobe ram_we
//  - COPY: driver rom, strobe ram_we
//  ram_cs=1 whenever ram_oe or ram_we is 1.
//  Latency: req sampled in IDLE -> done 3 cycles later (HOLD). Transaction = 4 cycles incl. IDLE, +1 with TURN.
//  Arbitration: single req -> that one. Both -> the one != last_winner. last_winner updates on the grant edge.
//  Handshake:
//  - op/addr need be valid only at the IDLE sampling edge; later changes are ignored.
//  - A requester drops req on the edge ending HOLD.
//  - req still high when IDLE is re-entered starts a new transaction (back-to-back allowed).
//  Boundary cases:
//  - req withdrawn after grant: transaction completes anyway.
//  - Reset mid-transaction: enables drop at once, transaction discarded, no done.
//  - Reset before the STROBE edge: RAM/register unchanged.
//  Addresses pass unmodified; no wrap logic (AW bits cover the full memory).
//  All outputs registered (decoded from state/latched op via flops) -> glitch-free enables.
// CONFIGURATION
//  BUS_TURNAROUND_EN defined: TURN state inserted after HOLD; at least 1 cycle with no driver
//    between transactions, so the contention Z flag shows 1 for that cycle.
//  BUS_TURNAROUND_EN undefined: HOLD -> IDLE. The driver changes only via IDLE, where all enables are 0.
// TESTING
//  1 Reset: n_reset=0 with req=11 -> all outputs 0, busy=0; release -> first grant=01.
//  2 req0 ROM_RD addr=3 -> grant=01 for 3 cycles; rom_cs/oe on; reg_oe 1 cycle; register=0010; done 1 pulse.
//  3 req1 SW_WR addr=5, switches=1010, then req0 RAM_RD addr=5 -> register=1010.
//  4 req=11 held, ops ROM_RD -> grants alternate 01,10,01,10; done every 4 cycles (5 with macro).
//  5 COPY addr=7, then RAM_RD addr=7 -> register=0100; contend=0 on every cycle of tests 2-5.
//  6 SW_WR addr=2 (RAM[2]=0000), n_reset low during SETUP -> enables 0 same cycle; RAM[2]=0000; no done.

Source files
------------

// File: rtl/playbus_controller.sv
// rtl/playbus_controller.sv - PlayBus two-requester bus sequencer/arbiter with registered enables
// BUS_TURNAROUND_EN: adds a TURN cycle with no bus driver after HOLD.
module playbus_controller #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [1:0]    req,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic [1:0]    grant,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] address,
  output logic          rom_cs,
  output logic          rom_oe,
  output logic          ram_cs,
  output logic          ram_oe,
  output logic          ram_we,
  output logic          buf_cs,
  output logic          buf_oe,
  output logic          reg_oe
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN} state_t;
  typedef enum logic [1:0] {OP_ROM_RD, OP_RAM_RD, OP_SW_WR, OP_COPY} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          win_q, win_d;
  logic          last_q, last_d;

  logic [1:0]    grant_q, grant_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] address_q, address_d;
  logic          rom_cs_q, rom_cs_d, rom_oe_q, rom_oe_d;
  logic          ram_cs_q, ram_cs_d, ram_oe_q, ram_oe_d, ram_we_q, ram_we_d;
  logic          buf_cs_q, buf_cs_d, buf_oe_q, buf_oe_d;
  logic          reg_oe_q, reg_oe_d;

  logic          drive, strobe;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    win_d   = win_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On contention the requester that did not win last time gets the bus
          if (req == 2'b11) win_d = ~last_q;
          else              win_d = req[1];
          last_d  = win_d;
          op_d    = win_d ? op_t'(op1) : op_t'(op0);
          addr_d  = win_d ? addr1 : addr0;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
`ifdef BUS_TURNAROUND_EN
        state_d = S_TURN;
`else
        state_d = S_IDLE;
`endif
      end
      S_TURN:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state so every enable comes straight off a flop
  always_comb begin
    drive     = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    strobe    = (state_d == S_STROBE);
    grant_d   = drive ? (win_d ? 2'b10 : 2'b01) : 2'b00;
    done_d    = (state_d == S_HOLD);
    busy_d    = (state_d != S_IDLE);
    address_d = drive ? addr_d : '0;
    rom_cs_d  = drive && ((op_d == OP_ROM_RD) || (op_d == OP_COPY));
    rom_oe_d  = rom_cs_d;
    ram_oe_d  = drive && (op_d == OP_RAM_RD);
    ram_we_d  = strobe && ((op_d == OP_SW_WR) || (op_d == OP_COPY));
    ram_cs_d  = ram_oe_d || ram_we_d;
    buf_cs_d  = drive && (op_d == OP_SW_WR);
    buf_oe_d  = buf_cs_d;
    reg_oe_d  = strobe && ((op_d == OP_ROM_RD) || (op_d == OP_RAM_RD));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ROM_RD;
      addr_q    <= '0;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      address_q <= '0;
      rom_cs_q  <= 1'b0;
      rom_oe_q  <= 1'b0;
      ram_cs_q  <= 1'b0;
      ram_oe_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      buf_cs_q  <= 1'b0;
      buf_oe_q  <= 1'b0;
      reg_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      win_q     <= win_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      address_q <= address_d;
      rom_cs_q  <= rom_cs_d;
      rom_oe_q  <= rom_oe_d;
      ram_cs_q  <= ram_cs_d;
      ram_oe_q  <= ram_oe_d;
      ram_we_q  <= ram_we_d;
      buf_cs_q  <= buf_cs_d;
      buf_oe_q  <= buf_oe_d;
      reg_oe_q  <= reg_oe_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign address = address_q;
  assign rom_cs  = rom_cs_q;
  assign rom_oe  = rom_oe_q;
  assign ram_cs  = ram_cs_q;
  assign ram_oe  = ram_oe_q;
  assign ram_we  = ram_we_q;
  assign buf_cs  = buf_cs_q;
  assign buf_oe  = buf_oe_q;
  assign reg_oe  = reg_oe_q;

endmodule
